// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and word helpers for the AES-256 key schedule controller.
package aes_ks_pkg;
   localparam int NWORDS = 60;
   localparam int NK     = 8;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT_RDY, ST_LOAD, ST_GEN, ST_SUB_WAIT, ST_DONE
   } ks_state_e;

   // Round constants consumed at i = 8, 16, ..., 56; the datapath steps them with xtime.
   localparam logic [7:0] RCON_TBL [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

   function automatic logic [0:31] rot_word(input logic [0:31] w);
      return {w[8:31], w[0:7]};
   endfunction
endpackage

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-expansion sequencer: streams w0..w59 to the round-key store and
// drives the shared subWord S-box unit for every fourth generated word.
module aes256_key_sched_ctrl #(
   parameter int SW_LAT = 1,
   parameter int NWORDS = aes_ks_pkg::NWORDS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [0:255] key_in,
   input  logic         sw_ready,
   output logic [0:31]  sw_in,
   input  logic [0:31]  sw_out,
   output logic         wk_valid,
   output logic [5:0]   wk_idx,
   output logic [0:31]  wk_data,
   output logic         busy,
   output logic         done
);
   import aes_ks_pkg::*;

   localparam int            CW       = $clog2(SW_LAT + 1);
   localparam logic [CW-1:0] LAT      = CW'(SW_LAT);
   localparam logic [5:0]    LAST_IDX = 6'(NWORDS - 1);

   ks_state_e     state_q, state_d;
   logic [0:31]   win_q [NK];
   logic [0:31]   win_d [NK];
   logic [5:0]    idx_q, idx_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [0:31]   sw_in_q, sw_in_d;
   logic          wk_valid_q, wk_valid_d;
   logic [5:0]    wk_idx_q, wk_idx_d;
   logic [0:31]   wk_data_q, wk_data_d;
   logic          done_q, done_d;

   logic [0:31]   p, q, sw_word, new_word;
   logic          issue, shift;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Window slot 7 is always w[i-1] and slot 0 is w[i-8] once LOAD has finished.
   assign p       = win_q[NK-1];
   assign q       = win_q[0];
   assign issue   = (state_q == ST_GEN) && sw_ready && (idx_q[1:0] == 2'b00);
   assign sw_word = (idx_q[2:0] == 3'd0) ? rot_word(p) : p;

   // The issue cycle shows the word combinationally so the S-box latency starts there.
   assign sw_in    = issue ? sw_word : sw_in_q;
   assign wk_valid = wk_valid_q;
   assign wk_idx   = wk_idx_q;
   assign wk_data  = wk_data_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      idx_d      = idx_q;
      rcon_d     = rcon_q;
      cnt_d      = cnt_q;
      sw_in_d    = sw_in_q;
      wk_valid_d = 1'b0;
      wk_idx_d   = wk_idx_q;
      wk_data_d  = wk_data_q;
      done_d     = 1'b0;
      shift      = 1'b0;
      new_word   = q ^ p;
      case (state_q)
         ST_IDLE: begin
            if (start && !done_q) begin
               for (int k = 0; k < NK; k++) win_d[k] = key_in[k*32 +: 32];
               rcon_d = RCON_TBL[0];
               if (sw_ready) begin
                  wk_valid_d = 1'b1;
                  wk_idx_d   = 6'd0;
                  wk_data_d  = key_in[0:31];
                  idx_d      = 6'd1;
                  state_d    = ST_LOAD;
               end else begin
                  idx_d   = 6'd0;
                  state_d = ST_WAIT_RDY;
               end
            end
         end
         ST_WAIT_RDY: begin
            if (sw_ready) begin
               wk_valid_d = 1'b1;
               wk_idx_d   = 6'd0;
               wk_data_d  = win_q[0];
               idx_d      = 6'd1;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            wk_valid_d = 1'b1;
            wk_idx_d   = idx_q;
            wk_data_d  = win_q[idx_q[2:0]];
            idx_d      = idx_q + 6'd1;
            if (idx_q[2:0] == 3'd7) state_d = ST_GEN;
         end
         ST_GEN: begin
            if (issue) begin
               sw_in_d = sw_word;
               cnt_d   = CW'(1);
               state_d = ST_SUB_WAIT;
            end else if (sw_ready) begin
               shift = 1'b1;
            end
         end
         ST_SUB_WAIT: begin
            if (cnt_q == LAT) begin
               new_word = q ^ sw_out ^ ((idx_q[2:0] == 3'd0) ? {rcon_q, 24'h0} : 32'h0);
               if (idx_q[2:0] == 3'd0) rcon_d = xtime(rcon_q);
               shift   = 1'b1;
               state_d = ST_GEN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (shift) begin
         for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
         win_d[NK-1] = new_word;
         wk_valid_d  = 1'b1;
         wk_idx_d    = idx_q;
         wk_data_d   = new_word;
         idx_d       = idx_q + 6'd1;
         if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         for (int k = 0; k < NK; k++) win_q[k] <= '0;
         idx_q      <= '0;
         rcon_q     <= RCON_TBL[0];
         cnt_q      <= '0;
         sw_in_q    <= '0;
         wk_valid_q <= 1'b0;
         wk_idx_q   <= '0;
         wk_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         idx_q      <= idx_d;
         rcon_q     <= rcon_d;
         cnt_q      <= cnt_d;
         sw_in_q    <= sw_in_d;
         wk_valid_q <= wk_valid_d;
         wk_idx_q   <= wk_idx_d;
         wk_data_q  <= wk_data_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl: behavioural subWord S-box next to a
// SW_LAT=1 and a SW_LAT=2 instance, with FIPS-197 and all-zero key vectors.
module tb_aes256_key_sched_ctrl;
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [0:255] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [0:255] KEY_ZERO = '0;
   localparam logic [0:255] KEY_ONES = {256{1'b1}};
   localparam logic [7:0]   RC_LIST [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

   logic         clk = 1'b0;
   logic         reset, start, start2, sw_ready, sw_ready2;
   logic [0:255] key_in;
   logic [0:31]  sw_in, sw_out, sw_in2, sw_mid2, sw_out2;
   logic         wk_valid, busy, done, wk_valid2, busy2, done2;
   logic [5:0]   wk_idx, wk_idx2;
   logic [0:31]  wk_data, wk_data2;

   int cyc = 0, t0 = 0, run_id = 0, checks = 0, errors = 0;
   int nvalid = 0, ndone = 0, busy_cnt = 0, busy_done = 0, order_bad = 0, done_cyc = 0;
   int b_valid, b_done, b_busy, b_bd, b_order;
   int prev_idx = 0, prev_run = -1;
   logic [0:31] got [60];
   int          got_cyc [60];
   int          got_run [60];
   logic [0:31] got2 [60];
   int          got2_cyc [60];
   int          got2_run [60];
   int          ndone2 = 0, done2_cyc = 0;
   logic [0:31] exp_w [60];

   aes256_key_sched_ctrl #(.SW_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .key_in(key_in), .sw_ready(sw_ready),
      .sw_in(sw_in), .sw_out(sw_out), .wk_valid(wk_valid), .wk_idx(wk_idx),
      .wk_data(wk_data), .busy(busy), .done(done));

   aes256_key_sched_ctrl #(.SW_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .key_in(key_in), .sw_ready(sw_ready2),
      .sw_in(sw_in2), .sw_out(sw_out2), .wk_valid(wk_valid2), .wk_idx(wk_idx2),
      .wk_data(wk_data2), .busy(busy2), .done(done2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[int'(x)*8 +: 8];
   endfunction

   function automatic logic [0:31] sub_word(input logic [0:31] w);
      logic [0:31] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = sbox(w[b*8 +: 8]);
      return r;
   endfunction

   // Registered S-box RAM models: one and two cycles of read latency.
   always @(posedge clk) begin
      sw_out  <= sub_word(sw_in);
      sw_mid2 <= sub_word(sw_in2);
      sw_out2 <= sw_mid2;
   end

   always @(negedge clk) begin
      if (wk_valid) begin
         nvalid++;
         if (wk_idx > 6'd59 || (prev_run == run_id && int'(wk_idx) <= prev_idx)) order_bad++;
         if (wk_idx <= 6'd59) begin
            got[wk_idx] = wk_data;
            got_cyc[wk_idx] = cyc;
            got_run[wk_idx] = run_id;
         end
         prev_idx = int'(wk_idx);
         prev_run = run_id;
      end
      if (busy) busy_cnt++;
      if (done) begin
         ndone++;
         done_cyc = cyc;
         if (busy) busy_done++;
      end
      if (wk_valid2 && wk_idx2 <= 6'd59) begin
         got2[wk_idx2] = wk_data2;
         got2_cyc[wk_idx2] = cyc;
         got2_run[wk_idx2] = run_id;
      end
      if (done2) begin
         ndone2++;
         done2_cyc = cyc;
      end
   end

   task automatic compute_ref(input logic [0:255] key);
      logic [0:31] t;
      for (int k = 0; k < 8; k++) exp_w[k] = key[k*32 +: 32];
      for (int k = 8; k < 60; k++) begin
         t = exp_w[k-1];
         if (k % 8 == 0) t = sub_word({t[8:31], t[0:7]}) ^ {RC_LIST[k/8 - 1], 24'h0};
         else if (k % 8 == 4) t = sub_word(t);
         exp_w[k] = exp_w[k-8] ^ t;
      end
   endtask

   task automatic launch(input logic [0:255] key);
      @(posedge clk); #1;
      key_in = key;
      start  = 1'b1;
      t0     = cyc;
      run_id++;
      b_valid = nvalid; b_done = ndone; b_busy = busy_cnt; b_bd = busy_done; b_order = order_bad;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start2 = 1'b0; sw_ready = 1'b1; sw_ready2 = 1'b1;
      key_in = '0;
      #1;
      checks++;
      if ({wk_valid, busy, done} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: valid/busy/done %b want 000", {wk_valid, busy, done});
      end
      checks++;
      if (wk_idx !== 6'd0 || wk_data !== 32'h0 || sw_in !== 32'h0) begin
         errors++; $display("FAIL reset_data: idx %0d data %h sw_in %h want 0", wk_idx, wk_data, sw_in);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_fips_a3();
      compute_ref(KEY_A3);
      launch(KEY_A3);
      @(posedge clk); #1 start = 1'b0;
      for (int n = 0; n < 300 && ndone == b_done; n++) begin @(negedge clk); #1; end
      checks++;
      if (ndone == b_done) begin errors++; $display("FAIL a3_timeout: done never seen"); end
      checks++;
      if (got[8] !== 32'h9ba35411) begin errors++; $display("FAIL a3_w8: got %h want 9ba35411", got[8]); end
      checks++;
      if (got[9] !== 32'h8e6925af) begin errors++; $display("FAIL a3_w9: got %h want 8e6925af", got[9]); end
      checks++;
      if (got[12] !== 32'ha8b09c1a) begin errors++; $display("FAIL a3_w12: got %h want a8b09c1a", got[12]); end
      checks++;
      if (got[59] !== 32'h706c631e) begin errors++; $display("FAIL a3_w59: got %h want 706c631e", got[59]); end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got_run[k] != run_id || got[k] !== exp_w[k]) begin
            errors++; $display("FAIL a3_word[%0d]: got %h want %h", k, got[k], exp_w[k]);
         end
      end
      checks++;
      if (got_cyc[0] - t0 != 1 || got_cyc[7] - t0 != 8) begin
         errors++; $display("FAIL a3_load_timing: w0 at %0d w7 at %0d want 1 and 8", got_cyc[0] - t0, got_cyc[7] - t0);
      end
      checks++;
      if (got_cyc[59] - t0 != 73) begin errors++; $display("FAIL a3_w59_cycle: got %0d want 73", got_cyc[59] - t0); end
      checks++;
      if (done_cyc - t0 != 74) begin errors++; $display("FAIL a3_done_cycle: got %0d want 74", done_cyc - t0); end
      checks++;
      if (busy_cnt - b_busy != 73 || busy_done != b_bd) begin
         errors++; $display("FAIL a3_busy: busy cycles %0d overlap %0d want 73 and 0", busy_cnt - b_busy, busy_done - b_bd);
      end
      checks++;
      if (nvalid - b_valid != 60 || order_bad != b_order) begin
         errors++; $display("FAIL a3_stream: words %0d order errs %0d want 60 and 0", nvalid - b_valid, order_bad - b_order);
      end
   endtask

   task automatic test_sw_ready_stall();
      compute_ref(KEY_ZERO);
      sw_ready = 1'b0;
      launch(KEY_ZERO);
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) sw_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || wk_valid !== 1'b0) begin
            errors++; $display("FAIL stall_wait[%0d]: busy %b valid %b want 1 0", c, busy, wk_valid);
         end
         @(posedge clk); #1;
      end
      while (cyc - t0 < 30) begin @(posedge clk); #1; end
      sw_ready = 1'b0;
      while (cyc - t0 < 33) begin @(posedge clk); #1; end
      sw_ready = 1'b1;
      for (int n = 0; n < 300 && ndone == b_done; n++) begin @(negedge clk); #1; end
      checks++;
      if (got_cyc[0] - t0 != 6) begin errors++; $display("FAIL stall_w0_cycle: got %0d want 6", got_cyc[0] - t0); end
      checks++;
      if (got[8] !== 32'h62636363) begin errors++; $display("FAIL zero_w8: got %h want 62636363", got[8]); end
      checks++;
      if (got[12] !== 32'haafbfbfb) begin errors++; $display("FAIL zero_w12: got %h want aafbfbfb", got[12]); end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got_run[k] != run_id || got[k] !== exp_w[k]) begin
            errors++; $display("FAIL stall_word[%0d]: got %h want %h", k, got[k], exp_w[k]);
         end
      end
      checks++;
      if (ndone - b_done != 1 || nvalid - b_valid != 60 || order_bad != b_order) begin
         errors++; $display("FAIL stall_stream: dones %0d words %0d order errs %0d want 1 60 0",
                            ndone - b_done, nvalid - b_valid, order_bad - b_order);
      end
   endtask

   task automatic test_start_ignored();
      compute_ref(KEY_A3);
      launch(KEY_A3);
      @(posedge clk); #1 start = 1'b0;
      while (cyc - t0 < 10) begin @(posedge clk); #1; end
      key_in = KEY_ONES; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (cyc - t0 < 40) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (cyc - t0 < 90) begin @(posedge clk); #1; end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got_run[k] != run_id || got[k] !== exp_w[k]) begin
            errors++; $display("FAIL ign_word[%0d]: got %h want %h", k, got[k], exp_w[k]);
         end
      end
      checks++;
      if (ndone - b_done != 1 || done_cyc - t0 != 74) begin
         errors++; $display("FAIL ign_done: dones %0d at %0d want 1 at 74", ndone - b_done, done_cyc - t0);
      end
      checks++;
      if (nvalid - b_valid != 60 || order_bad != b_order) begin
         errors++; $display("FAIL ign_stream: words %0d order errs %0d want 60 0", nvalid - b_valid, order_bad - b_order);
      end
   endtask

   task automatic test_reset_mid();
      launch(KEY_A3);
      @(posedge clk); #1 start = 1'b0;
      while (cyc - t0 < 30) begin @(posedge clk); #1; end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({wk_valid, busy, done} !== 3'b000) begin
         errors++; $display("FAIL midrst_ctrl: valid/busy/done %b want 000", {wk_valid, busy, done});
      end
      checks++;
      if (wk_idx !== 6'd0 || wk_data !== 32'h0 || sw_in !== 32'h0) begin
         errors++; $display("FAIL midrst_data: idx %0d data %h sw_in %h want 0", wk_idx, wk_data, sw_in);
      end
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (ndone != b_done) begin errors++; $display("FAIL midrst_done: %0d dones want 0", ndone - b_done); end
      compute_ref(KEY_ZERO);
      launch(KEY_ZERO);
      @(posedge clk); #1 start = 1'b0;
      for (int n = 0; n < 300 && ndone == b_done; n++) begin @(negedge clk); #1; end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got_run[k] != run_id || got[k] !== exp_w[k]) begin
            errors++; $display("FAIL midrst_word[%0d]: got %h want %h", k, got[k], exp_w[k]);
         end
      end
      checks++;
      if (ndone - b_done != 1 || done_cyc - t0 != 74) begin
         errors++; $display("FAIL midrst_redo_done: dones %0d at %0d want 1 at 74", ndone - b_done, done_cyc - t0);
      end
   endtask

   task automatic test_back_to_back();
      launch(KEY_A3);
      for (int n = 0; n < 300 && ndone == b_done; n++) begin @(negedge clk); #1; end
      checks++;
      if (done_cyc - t0 != 74 || got[59] !== 32'h706c631e) begin
         errors++; $display("FAIL b2b_first: done at %0d w59 %h want 74 706c631e", done_cyc - t0, got[59]);
      end
      key_in = KEY_ZERO;
      @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (wk_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_done_cycle_start: valid %b busy %b want 0 0", wk_valid, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc - 1;
      run_id++;
      b_valid = nvalid; b_done = ndone; b_order = order_bad;
      compute_ref(KEY_ZERO);
      for (int n = 0; n < 300 && ndone == b_done; n++) begin @(negedge clk); #1; end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got_run[k] != run_id || got[k] !== exp_w[k]) begin
            errors++; $display("FAIL b2b_word[%0d]: got %h want %h", k, got[k], exp_w[k]);
         end
      end
      checks++;
      if (done_cyc - t0 != 74 || got_cyc[0] - t0 != 1) begin
         errors++; $display("FAIL b2b_second_timing: w0 at %0d done at %0d want 1 and 74", got_cyc[0] - t0, done_cyc - t0);
      end
   endtask

   task automatic test_sw_lat2();
      int d0;
      compute_ref(KEY_A3);
      d0 = ndone2;
      @(posedge clk); #1;
      key_in = KEY_A3; start2 = 1'b1; t0 = cyc; run_id++;
      @(posedge clk); #1 start2 = 1'b0;
      for (int n = 0; n < 300 && ndone2 == d0; n++) begin @(negedge clk); #1; end
      checks++;
      if (ndone2 != d0 + 1) begin errors++; $display("FAIL lat2_done_count: got %0d want 1", ndone2 - d0); end
      for (int k = 0; k < 60; k++) begin
         checks++;
         if (got2_run[k] != run_id || got2[k] !== exp_w[k]) begin
            errors++; $display("FAIL lat2_word[%0d]: got %h want %h", k, got2[k], exp_w[k]);
         end
      end
      checks++;
      if (got2_cyc[59] - t0 != 86 || done2_cyc - t0 != 87) begin
         errors++; $display("FAIL lat2_timing: w59 at %0d done at %0d want 86 and 87", got2_cyc[59] - t0, done2_cyc - t0);
      end
   endtask

   initial begin
      test_reset();
      test_fips_a3();
      test_sw_ready_stall();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_sw_lat2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
